// File: rtl/emern_spi_pkg.sv
// Shared types and constants for the EMERN SPI host.
package emern_spi_pkg;

   localparam int BYTE_W = 8;

   // Mode 0: SCK idles low, data sampled on the rising edge.
   localparam logic CPOL = 1'b0;
   localparam logic CPHA = 1'b0;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_SYNC,
      SETUP,
      SHIFT,
      NEXT,
      HOLD,
      GAP
   } state_e;

endpackage

// File: rtl/emern_sync_edge.sv
// Two-flop synchronizer with a rising-edge detect on the synchronized level.
module emern_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic rise
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic prev_q, prev_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
      prev_d = sync_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/emern_spi_host.sv
// SPI mode-0 master: frames a valid/ready byte stream into CS-delimited transfers,
// optionally waiting for a GPU INT rising edge before starting a frame.
module emern_spi_host
   import emern_spi_pkg::*;
#(
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2,
   parameter int CS_IDLE  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [BYTE_W-1:0] tx_data,
   input  logic              tx_valid,
   input  logic              tx_last,
   input  logic              tx_sync,
   output logic              tx_ready,
   output logic [BYTE_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              busy,
   output logic              cs_n,
   output logic              sck,
   output logic              mosi,
   input  logic              miso,
   input  logic              int_in
);

   localparam int CNT_W = 16;
   // The first low phase of bit 7 counts towards the CS setup time, so SETUP
   // itself only covers the remaining half-periods (possibly none).
   localparam int SETUP_CYC = (CS_SETUP - 1) * CLK_DIV;

   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
   localparam logic [CNT_W-1:0] HALF_LD  = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(CS_HOLD * CLK_DIV - 1);
   localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(CS_IDLE * CLK_DIV - 1);
   localparam state_e           FIRST_ST = (SETUP_CYC > 0) ? SETUP : SHIFT;
   localparam logic [CNT_W-1:0] FIRST_LD = (SETUP_CYC > 0) ? SETUP_LD : HALF_LD;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        bit_q, bit_d;
   logic [6:0]        tx_sh_q, tx_sh_d;
   logic [BYTE_W-1:0] rx_sh_q, rx_sh_d;
   logic              last_q, last_d;
   logic              cs_n_q, cs_n_d;
   logic              sck_q, sck_d;
   logic              mosi_q, mosi_d;
   logic [BYTE_W-1:0] rx_data_q, rx_data_d;
   logic              rx_valid_q, rx_valid_d;
   logic              cnt_zero;
   logic              int_rise;

   emern_sync_edge u_int_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (int_in),
      .rise  (int_rise)
   );

   assign cnt_zero = (cnt_q == '0);
   assign tx_ready = (state_q == IDLE) || (state_q == NEXT);
   assign busy     = (state_q != IDLE);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      tx_sh_d    = tx_sh_q;
      rx_sh_d    = rx_sh_q;
      last_d     = last_q;
      cs_n_d     = cs_n_q;
      sck_d      = sck_q;
      mosi_d     = mosi_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (tx_valid) begin
               tx_sh_d = tx_data[6:0];
               mosi_d  = tx_data[7];
               last_d  = tx_last;
               bit_d   = 3'd7;
               if (tx_sync) begin
                  state_d = WAIT_SYNC;
               end else begin
                  cs_n_d  = 1'b0;
                  state_d = FIRST_ST;
                  cnt_d   = FIRST_LD;
               end
            end
         end
         WAIT_SYNC: begin
            if (int_rise) begin
               cs_n_d  = 1'b0;
               state_d = FIRST_ST;
               cnt_d   = FIRST_LD;
            end
         end
         SETUP: begin
            if (cnt_zero) begin
               state_d = SHIFT;
               cnt_d   = HALF_LD;
            end else begin
               cnt_d = cnt_q - ONE;
            end
         end
         SHIFT: begin
            if (!cnt_zero) begin
               cnt_d = cnt_q - ONE;
            end else begin
               cnt_d = HALF_LD;
               if (!sck_q) begin
                  sck_d   = 1'b1;
                  rx_sh_d = {rx_sh_q[6:0], miso};
               end else begin
                  sck_d = 1'b0;
                  if (bit_q == 3'd0) begin
                     rx_data_d  = rx_sh_q;
                     rx_valid_d = 1'b1;
                     if (last_q) begin
                        state_d = HOLD;
                        cnt_d   = HOLD_LD;
                     end else begin
                        state_d = NEXT;
                     end
                  end else begin
                     bit_d   = bit_q - 3'd1;
                     mosi_d  = tx_sh_q[6];
                     tx_sh_d = {tx_sh_q[5:0], 1'b0};
                  end
               end
            end
         end
         NEXT: begin
            if (tx_valid) begin
               tx_sh_d = tx_data[6:0];
               mosi_d  = tx_data[7];
               last_d  = tx_last;
               bit_d   = 3'd7;
               state_d = SHIFT;
               cnt_d   = HALF_LD;
            end
         end
         HOLD: begin
            if (cnt_zero) begin
               cs_n_d  = 1'b1;
               mosi_d  = 1'b0;
               state_d = GAP;
               cnt_d   = GAP_LD;
            end else begin
               cnt_d = cnt_q - ONE;
            end
         end
         GAP: begin
            if (cnt_zero) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - ONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         bit_q      <= 3'd7;
         tx_sh_q    <= '0;
         rx_sh_q    <= '0;
         last_q     <= 1'b0;
         cs_n_q     <= 1'b1;
         sck_q      <= CPOL;
         mosi_q     <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         tx_sh_q    <= tx_sh_d;
         rx_sh_q    <= rx_sh_d;
         last_q     <= last_d;
         cs_n_q     <= cs_n_d;
         sck_q      <= sck_d;
         mosi_q     <= mosi_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
      end
   end

   assign cs_n     = cs_n_q;
   assign sck      = sck_q;
   assign mosi     = mosi_q;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_emern_spi_host.sv
// Directed bench for emern_spi_host: u0 runs CLK_DIV=2, u1 runs CLK_DIV=1.
module tb_emern_spi_host;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] tx_data;
   logic       tx_valid, tx_valid1, tx_last, tx_sync;
   logic       int_in;
   logic       miso, miso1;
   logic       tx_ready, rx_valid, busy, cs_n, sck, mosi;
   logic       tx_ready1, rx_valid1, busy1, cs1_n, sck1, mosi1;
   logic [7:0] rx_data, rx_data1;

   emern_spi_host #(.CLK_DIV(2), .CS_SETUP(2), .CS_HOLD(2), .CS_IDLE(2)) u0 (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_last(tx_last), .tx_sync(tx_sync), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .cs_n(cs_n),
      .sck(sck), .mosi(mosi), .miso(miso), .int_in(int_in)
   );

   emern_spi_host #(.CLK_DIV(1), .CS_SETUP(2), .CS_HOLD(2), .CS_IDLE(2)) u1 (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid1),
      .tx_last(tx_last), .tx_sync(tx_sync), .tx_ready(tx_ready1),
      .rx_data(rx_data1), .rx_valid(rx_valid1), .busy(busy1), .cs_n(cs1_n),
      .sck(sck1), .mosi(mosi1), .miso(miso1), .int_in(int_in)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // u0 observer and miso slave model, updated away from the active edge.
   int          n_rise, n_fall, n_csf, n_rxv, t_csf, t_rise1, t_fall, t_csr, t_busyf, nb;
   logic [31:0] mosi_bits;
   logic [7:0]  rx_got [4];
   logic [7:0]  slv [4];
   logic        loop = 1'b0;
   logic        p_sck = 1'b0, p_cs = 1'b1, p_busy = 1'b0;

   initial begin : mon0
      logic [7:0] cur;
      nb = 0;
      forever begin
         @(negedge clk);
         if (!cs_n && p_cs) begin n_csf++; t_csf = cyc; end
         if (cs_n && !p_cs) t_csr = cyc;
         if (!busy && p_busy) t_busyf = cyc;
         if (sck && !p_sck) begin
            if (n_rise == 0) t_rise1 = cyc;
            n_rise++;
            mosi_bits = {mosi_bits[30:0], mosi};
         end
         if (!sck && p_sck) begin n_fall++; t_fall = cyc; end
         if (rx_valid) begin
            if (n_rxv < 4) rx_got[n_rxv] = rx_data;
            n_rxv++;
         end
         if (cs_n) nb = 0;
         else if (!sck && p_sck) nb++;
         cur = slv[(nb / 8) % 4];
         if (cs_n) miso = 1'b0;
         else if (loop) miso = mosi;
         else miso = cur[3'(7 - (nb % 8))];
         p_sck = sck; p_cs = cs_n; p_busy = busy;
      end
   end

   // u1 observer and slave.
   int         r1, tg1, nrx1, t1_csf, t1_r1, t1_f, nb1;
   logic [7:0] m1, rx1, slv1;
   logic       p_sck1 = 1'b0, p_cs1 = 1'b1;

   initial begin : mon1
      nb1 = 0;
      forever begin
         @(negedge clk);
         if (!cs1_n && p_cs1) t1_csf = cyc;
         if (sck1 != p_sck1) tg1++;
         if (sck1 && !p_sck1) begin
            if (r1 == 0) t1_r1 = cyc;
            r1++;
            m1 = {m1[6:0], mosi1};
         end
         if (!sck1 && p_sck1) t1_f = cyc;
         if (rx_valid1) begin rx1 = rx_data1; nrx1++; end
         if (cs1_n) nb1 = 0;
         else if (!sck1 && p_sck1) nb1++;
         miso1 = cs1_n ? 1'b0 : slv1[3'(7 - (nb1 % 8))];
         p_sck1 = sck1; p_cs1 = cs1_n;
      end
   end

   task automatic clr();
      n_rise = 0; n_fall = 0; n_csf = 0; n_rxv = 0; mosi_bits = '0;
      t_csf = 0; t_rise1 = 0; t_fall = 0; t_csr = 0; t_busyf = 0;
      for (int i = 0; i < 4; i++) rx_got[i] = 8'h00;
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge with valid still high.
   task automatic push(input logic sel, input logic [7:0] d, input logic l, input logic s);
      int n;
      tx_data = d; tx_last = l; tx_sync = s;
      if (sel) tx_valid1 = 1'b1; else tx_valid = 1'b1;
      n = 0;
      while (!(sel ? tx_ready1 : tx_ready) && n < 2000) begin @(negedge clk); n++; end
      if (!(sel ? tx_ready1 : tx_ready)) chk("push_timeout", 32'd0, 32'd1);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_idle(input logic sel);
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while ((sel ? busy1 : busy) && n < 3000);
      if (sel ? busy1 : busy) chk("idle_timeout", 32'd0, 32'd1);
      repeat (2) @(negedge clk);
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int n, t_int;
      rst_n = 1'b0; tx_data = 8'h00; tx_valid = 1'b0; tx_valid1 = 1'b0;
      tx_last = 1'b0; tx_sync = 1'b0; int_in = 1'b1;
      r1 = 0; tg1 = 0; nrx1 = 0; m1 = '0; rx1 = '0; slv1 = 8'h00;
      t1_csf = 0; t1_r1 = 0; t1_f = 0;
      for (int i = 0; i < 4; i++) slv[i] = 8'h00;
      clr();
      repeat (3) @(negedge clk);
      #1;
      chk("rst_cs_n", cs_n, 1);
      chk("rst_sck", sck, 0);
      chk("rst_mosi", mosi, 0);
      chk("rst_rx_data", rx_data, 0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_tx_ready", tx_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Single byte 0xA5, slave returns 0x3C.
      clr(); slv[0] = 8'h3C;
      push(1'b0, 8'hA5, 1'b1, 1'b0);
      tx_valid = 1'b0;
      wait_idle(1'b0);
      chk("t1_cs_falls", n_csf, 1);
      chk("t1_setup", t_rise1 - t_csf, 4);
      chk("t1_rises", n_rise, 8);
      chk("t1_mosi", mosi_bits[7:0], 8'hA5);
      chk("t1_rx_cnt", n_rxv, 1);
      chk("t1_rx_data", rx_got[0], 8'h3C);
      chk("t1_hold", t_csr - t_fall, 4);
      chk("t1_gap", t_busyf - t_csr, 4);

      // Burst with valid held high, miso looped back to mosi.
      clr(); loop = 1'b1;
      push(1'b0, 8'h01, 1'b0, 1'b0);
      push(1'b0, 8'hFF, 1'b0, 1'b0);
      push(1'b0, 8'h80, 1'b1, 1'b0);
      tx_valid = 1'b0;
      wait_idle(1'b0);
      loop = 1'b0;
      chk("t2_cs_falls", n_csf, 1);
      chk("t2_rises", n_rise, 24);
      chk("t2_mosi", mosi_bits[23:0], 24'h01FF80);
      chk("t2_rx_cnt", n_rxv, 3);
      chk("t2_rx0", rx_got[0], 8'h01);
      chk("t2_rx1", rx_got[1], 8'hFF);
      chk("t2_rx2", rx_got[2], 8'h80);

      // Stall in NEXT for 20 clk between bytes.
      clr(); slv[0] = 8'h96; slv[1] = 8'h69;
      push(1'b0, 8'h11, 1'b0, 1'b0);
      tx_valid = 1'b0;
      n = 0;
      while (n_rxv < 1 && n < 2000) begin @(negedge clk); n++; end
      chk("t3_reach_next", n_rxv, 1);
      repeat (20) @(negedge clk);
      chk("t3_stall_cs_n", cs_n, 0);
      chk("t3_stall_sck", sck, 0);
      chk("t3_stall_ready", tx_ready, 1);
      chk("t3_stall_rises", n_rise, 8);
      push(1'b0, 8'h22, 1'b1, 1'b0);
      tx_valid = 1'b0;
      wait_idle(1'b0);
      chk("t3_cs_falls", n_csf, 1);
      chk("t3_rises", n_rise, 16);
      chk("t3_mosi", mosi_bits[15:0], 16'h1122);
      chk("t3_rx0", rx_got[0], 8'h96);
      chk("t3_rx1", rx_got[1], 8'h69);

      // Sync wait with int_in already high.
      clr(); slv[0] = 8'h81;
      push(1'b0, 8'hE7, 1'b1, 1'b1);
      tx_valid = 1'b0; tx_sync = 1'b0;
      repeat (10) @(negedge clk);
      chk("t4_no_start_hi", n_csf, 0);
      chk("t4_cs_n_hi", cs_n, 1);
      int_in = 1'b0;
      repeat (5) @(negedge clk);
      chk("t4_no_start_lo", n_csf, 0);
      int_in = 1'b1;
      t_int = cyc;
      wait_idle(1'b0);
      chk("t4_int_to_cs", t_csf - t_int, 3);
      chk("t4_mosi", mosi_bits[7:0], 8'hE7);
      chk("t4_rx", rx_got[0], 8'h81);

      // Reset during the third high phase.
      clr(); slv[0] = 8'hFF;
      push(1'b0, 8'hF0, 1'b1, 1'b0);
      tx_valid = 1'b0;
      n = 0;
      while (n_rise < 3 && n < 2000) begin @(negedge clk); n++; end
      chk("t5_reach_rise3", n_rise, 3);
      rst_n = 1'b0;
      #1;
      chk("t5_cs_n", cs_n, 1);
      chk("t5_sck", sck, 0);
      chk("t5_mosi", mosi, 0);
      chk("t5_busy", busy, 0);
      chk("t5_rx_valid", rx_valid, 0);
      chk("t5_rx_data", rx_data, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("t5_no_rx", n_rxv, 0);
      clr(); slv[0] = 8'hA5;
      push(1'b0, 8'h5A, 1'b1, 1'b0);
      tx_valid = 1'b0;
      wait_idle(1'b0);
      chk("t5_after_rises", n_rise, 8);
      chk("t5_after_setup", t_rise1 - t_csf, 4);
      chk("t5_after_mosi", mosi_bits[7:0], 8'h5A);
      chk("t5_after_rx", rx_got[0], 8'hA5);

      // CLK_DIV=1 instance.
      r1 = 0; tg1 = 0; nrx1 = 0; slv1 = 8'h69;
      push(1'b1, 8'hC3, 1'b1, 1'b0);
      tx_valid1 = 1'b0;
      wait_idle(1'b1);
      chk("t6_setup", t1_r1 - t1_csf, 2);
      chk("t6_span", t1_f - t1_r1, 15);
      chk("t6_rises", r1, 8);
      chk("t6_toggles", tg1, 16);
      chk("t6_mosi", m1, 8'hC3);
      chk("t6_rx_cnt", nrx1, 1);
      chk("t6_rx", rx1, 8'h69);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
